// File: rtl/beep_pkg.sv
// Shared types and helpers for the key-driven buzzer controller.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEEP  = 2'd1,
        GAP   = 2'd2,
        BEEP2 = 2'd3
    } beep_state_e;

    localparam logic [2:0] KEY_NONE = 3'd0;
    localparam logic [2:0] KEY1     = 3'd1;
    localparam logic [2:0] KEY2     = 3'd2;
    localparam logic [2:0] KEY3     = 3'd3;
    localparam logic [2:0] KEY4     = 3'd4;

    function automatic logic key_is_valid(input logic [2:0] code);
        return (code >= KEY1) && (code <= KEY4);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_beep_ctrl_tone_gen.sv
// Half-period counter and square-wave phase for the buzzer tone.
// The phase is forced low whenever the tone is silent, so it can drive the buzzer directly.
module tone_gen #(
    parameter int CNT_W = 2,
    parameter int HP_W  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    input  logic [HP_W-1:0] half_period,
    output logic            phase
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             wrap;

    // clear starts a fresh tone at phase 1; enable low means the next cycle is silent
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        wrap    = (HP_W'(cnt_q) == (half_period - HP_W'(1)));
        if (clear) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (enable) begin
            if (wrap) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/key_beep_ctrl.sv
// Turns one-cycle key code pulses into single or double tone bursts on a passive buzzer.
module key_beep_ctrl
    import beep_pkg::*;
#(
    parameter int   HP1        = 25000,
    parameter int   HP2        = 12500,
    parameter int   HP3        = 6250,
    parameter int   HP4        = 12500,
    parameter int   BEEP_CYC   = 5000000,
    parameter int   GAP_CYC    = 2500000,
    parameter logic ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_val,
    output logic       buzz_out,
    output logic       busy,
    output logic       beep_done,
    output logic [2:0] active_key
);

    localparam int HP_MAX = max2(max2(HP1, HP2), max2(HP3, HP4));
    localparam int HP_W   = $clog2(HP_MAX + 1);
    localparam int CNT_W  = max2(1, $clog2(HP_MAX));
    localparam int DUR_W  = max2(1, $clog2(max2(BEEP_CYC, GAP_CYC)));

    beep_state_e      state_q, state_d;
    logic [2:0]       key_q, key_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             busy_q, busy_d;
    logic             accept, terminal, toneClear, toneEnable, phase;
    logic             beepLast, gapLast;

    assign beepLast = (dur_q == DUR_W'(BEEP_CYC - 1));
    assign gapLast  = (dur_q == DUR_W'(GAP_CYC - 1));

    // A valid key always wins over whatever the pattern would have done this cycle
    always_comb begin
        accept     = key_is_valid(key_val);
        state_d    = state_q;
        key_d      = key_q;
        hp_d       = hp_q;
        dur_d      = dur_q + DUR_W'(1);
        toneClear  = 1'b0;
        terminal   = 1'b0;
        case (state_q)
            IDLE: dur_d = '0;
            BEEP: begin
                if (beepLast) begin
                    dur_d = '0;
                    if (key_q == KEY4) begin
                        state_d = GAP;
                    end else begin
                        state_d  = IDLE;
                        terminal = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gapLast) begin
                    dur_d     = '0;
                    state_d   = BEEP2;
                    toneClear = 1'b1;
                end
            end
            BEEP2: begin
                if (beepLast) begin
                    dur_d    = '0;
                    state_d  = IDLE;
                    terminal = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                dur_d   = '0;
            end
        endcase
        if (accept) begin
            state_d   = BEEP;
            key_d     = key_val;
            dur_d     = '0;
            toneClear = 1'b1;
            case (key_val)
                KEY1:    hp_d = HP_W'(HP1);
                KEY2:    hp_d = HP_W'(HP2);
                KEY3:    hp_d = HP_W'(HP3);
                default: hp_d = HP_W'(HP4);
            endcase
        end
        if (state_d == IDLE) begin
            key_d = KEY_NONE;
        end
        busy_d     = (state_d != IDLE);
        toneEnable = (state_d == BEEP) || (state_d == BEEP2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= KEY_NONE;
            hp_q    <= '0;
            dur_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            hp_q    <= hp_d;
            dur_q   <= dur_d;
            busy_q  <= busy_d;
        end
    end

    tone_gen #(
        .CNT_W (CNT_W),
        .HP_W  (HP_W)
    ) u_tone (
        .clk         (clk),
        .rst         (rst),
        .clear       (toneClear),
        .enable      (toneEnable),
        .half_period (hp_d),
        .phase       (phase)
    );

    // beep_done is qualified by the incoming key so a colliding retrigger suppresses it
    assign beep_done  = terminal && !accept;
    assign buzz_out   = phase ^ ACTIVE_LOW;
    assign busy       = busy_q;
    assign active_key = key_q;

endmodule

// File: tb/tb_key_beep_ctrl.sv
// Scoreboard bench: scenarios queue per-cycle expectations, a negedge monitor pops and compares.
module tb_key_beep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_val;
    logic       buzz_out, busy, beep_done;
    logic [2:0] active_key;

    typedef struct {
        logic       busy;
        logic [2:0] key;
        logic       buzz;
        logic       done;
    } exp_t;

    exp_t  expQ[$];
    exp_t  monRec;
    int    checks = 0;
    int    errors = 0;
    int    cycIdx = 0;
    string tag    = "init";

    key_beep_ctrl #(
        .HP1(2), .HP2(3), .HP3(4), .HP4(3),
        .BEEP_CYC(20), .GAP_CYC(10), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_val    (key_val),
        .buzz_out   (buzz_out),
        .busy       (busy),
        .beep_done  (beep_done),
        .active_key (active_key)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input exp_t e);
        checks++;
        if (busy !== e.busy) begin
            errors++;
            $display("[TB] FAIL %s busy got=%b exp=%b", name, busy, e.busy);
        end
        checks++;
        if (active_key !== e.key) begin
            errors++;
            $display("[TB] FAIL %s active_key got=%0d exp=%0d", name, active_key, e.key);
        end
        checks++;
        if (buzz_out !== e.buzz) begin
            errors++;
            $display("[TB] FAIL %s buzz_out got=%b exp=%b", name, buzz_out, e.buzz);
        end
        checks++;
        if (beep_done !== e.done) begin
            errors++;
            $display("[TB] FAIL %s beep_done got=%b exp=%b", name, beep_done, e.done);
        end
    endtask

    task automatic expIdle(input int n);
        exp_t e;
        e.busy = 1'b0; e.key = 3'd0; e.buzz = 1'b0; e.done = 1'b0;
        for (int i = 0; i < n; i++) expQ.push_back(e);
    endtask

    task automatic expTone(input logic [2:0] k, input int hp, input int n, input logic doneLast);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.busy = 1'b1;
            e.key  = k;
            e.buzz = (((i / hp) % 2) == 0);
            e.done = doneLast && (i == n - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic expGap(input logic [2:0] k, input int n);
        exp_t e;
        e.busy = 1'b1; e.key = k; e.buzz = 1'b0; e.done = 1'b0;
        for (int i = 0; i < n; i++) expQ.push_back(e);
    endtask

    // Called at posedge+1; cycle 0 of the scenario is the current cycle
    task automatic applyStimulus(input int c1, input logic [2:0] k1,
                                 input int c2, input logic [2:0] k2,
                                 input int c3, input logic [2:0] k3,
                                 input int n);
        for (int c = 0; c < n; c++) begin
            if (c == c1)      key_val = k1;
            else if (c == c2) key_val = k2;
            else if (c == c3) key_val = k3;
            else              key_val = 3'd0;
            @(posedge clk);
            #1;
        end
        key_val = 3'd0;
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monRec = expQ.pop_front();
            checkOutput($sformatf("%s_c%0d", tag, cycIdx), monRec);
            cycIdx++;
        end
    end

    initial begin
        exp_t idleRec;
        exp_t preRec;
        idleRec.busy = 1'b0; idleRec.key = 3'd0; idleRec.buzz = 1'b0; idleRec.done = 1'b0;
        rst     = 1'b1;
        key_val = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", idleRec);
        rst = 1'b0;

        tag = "key1"; cycIdx = 0;
        expIdle(1); expTone(3'd1, 2, 20, 1'b1); expIdle(2);
        applyStimulus(0, 3'd1, -1, 3'd0, -1, 3'd0, 23);

        tag = "key4"; cycIdx = 0;
        expIdle(1); expTone(3'd4, 3, 20, 1'b0); expGap(3'd4, 10);
        expTone(3'd4, 3, 20, 1'b1); expIdle(2);
        applyStimulus(0, 3'd4, -1, 3'd0, -1, 3'd0, 53);

        tag = "retrig"; cycIdx = 0;
        expIdle(1); expTone(3'd1, 2, 7, 1'b0); expTone(3'd3, 4, 20, 1'b1); expIdle(2);
        applyStimulus(0, 3'd1, 7, 3'd3, -1, 3'd0, 30);

        tag = "invIdle"; cycIdx = 0;
        expIdle(4);
        applyStimulus(0, 3'd5, 1, 3'd6, 2, 3'd7, 4);

        tag = "invBusy"; cycIdx = 0;
        expIdle(1); expTone(3'd2, 3, 20, 1'b1); expIdle(2);
        applyStimulus(0, 3'd2, 5, 3'd6, -1, 3'd0, 23);

        tag = "collide"; cycIdx = 0;
        expIdle(1); expTone(3'd1, 2, 20, 1'b0); expTone(3'd2, 3, 20, 1'b1); expIdle(2);
        applyStimulus(0, 3'd1, 20, 3'd2, -1, 3'd0, 43);

        // Asynchronous reset in the middle of a key-1 beep, checked before the next edge
        applyStimulus(0, 3'd1, -1, 3'd0, -1, 3'd0, 6);
        preRec.busy = 1'b1; preRec.key = 3'd1; preRec.buzz = 1'b1; preRec.done = 1'b0;
        checkOutput("preReset", preRec);
        #2 rst = 1'b1;
        #1 checkOutput("midReset", idleRec);
        @(posedge clk);
        #1 rst = 1'b0;

        tag = "postReset"; cycIdx = 0;
        expIdle(3);
        applyStimulus(-1, 3'd0, -1, 3'd0, -1, 3'd0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
